// File: rtl/sha2indctrl_if.sv
// rtl/sha2indctrl_if.sv - packet and block handshake bundle between source, datapath and sha2indctrl
interface sha2indctrl_if;
  logic       in_vld;
  logic       in_last;
  logic       in_rdy;
  logic [2:0] idx;
  logic       clr;
  logic       st_pkt;
  logic       pad_pkt;
  logic       zero_pkt;
  logic       mgln_pkt;
  logic       blk_vld;
  logic       blk_last;
  logic       blk_ack;

  modport master (
    input  in_vld, in_last, idx, blk_ack,
    output in_rdy, clr, st_pkt, pad_pkt, zero_pkt, mgln_pkt, blk_vld, blk_last
  );

  modport slave (
    output in_vld, in_last, idx, blk_ack,
    input  in_rdy, clr, st_pkt, pad_pkt, zero_pkt, mgln_pkt, blk_vld, blk_last
  );
endinterface

// File: rtl/sha2indctrl.sv
// rtl/sha2indctrl.sv - SHA-2 input control: sequences data, pad, zero and length packets into 512-bit blocks
module sha2indctrl (
  input  logic          clk,
  input  logic          rst_b,
  sha2indctrl_if.master bus
);

  typedef enum logic [2:0] {S_CLR, S_LOAD, S_PAD, S_ZERO, S_MGLN, S_FULL} state_t;
  typedef enum logic [1:0] {R_LOAD, R_PAD, R_ZERO, R_CLR} rsm_t;

  state_t state, state_nxt;
  rsm_t   rsm, rsm_nxt;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= S_CLR;
      rsm   <= R_LOAD;
    end else begin
      state <= state_nxt;
      rsm   <= rsm_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rsm_nxt      = rsm;
    bus.in_rdy   = 1'b0;
    bus.clr      = 1'b0;
    bus.st_pkt   = 1'b0;
    bus.pad_pkt  = 1'b0;
    bus.zero_pkt = 1'b0;
    bus.mgln_pkt = 1'b0;
    bus.blk_vld  = 1'b0;
    bus.blk_last = 1'b0;
    case (state)
      S_CLR: begin
        bus.clr   = 1'b1;
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        bus.in_rdy = 1'b1;
        bus.st_pkt = bus.in_vld;
        if (bus.in_vld) begin
          // Filling slot 7 completes a block; rsm remembers whether padding is still owed.
          if (bus.idx == 3'd7) begin
            state_nxt = S_FULL;
            rsm_nxt   = bus.in_last ? R_PAD : R_LOAD;
          end else if (bus.in_last) begin
            state_nxt = S_PAD;
          end
        end
      end
      S_PAD: begin
        bus.st_pkt  = 1'b1;
        bus.pad_pkt = 1'b1;
        if (bus.idx == 3'd7) begin
          state_nxt = S_FULL;
          rsm_nxt   = R_ZERO;
        end else if (bus.idx == 3'd6) begin
          state_nxt = S_MGLN;
        end else begin
          state_nxt = S_ZERO;
        end
      end
      S_ZERO: begin
        bus.st_pkt   = 1'b1;
        bus.zero_pkt = 1'b1;
        if (bus.idx == 3'd6) state_nxt = S_MGLN;
      end
      S_MGLN: begin
        bus.st_pkt   = 1'b1;
        bus.mgln_pkt = 1'b1;
        state_nxt    = S_FULL;
        rsm_nxt      = R_CLR;
      end
      S_FULL: begin
        bus.blk_vld  = 1'b1;
        bus.blk_last = (rsm == R_CLR);
        if (bus.blk_ack) begin
          case (rsm)
            R_LOAD:  state_nxt = S_LOAD;
            R_PAD:   state_nxt = S_PAD;
            R_ZERO:  state_nxt = S_ZERO;
            default: state_nxt = S_CLR;
          endcase
        end
      end
      default: state_nxt = S_CLR;
    endcase
  end

endmodule
